// File: rtl/case_7_sdiv_26s_12s_26_seq.sv
// Sequential signed divider (radix-2 restoring) with start/done handshake.
// Truncating C-style semantics; quotient/remainder/flags held until the next result.
module case_7_sdiv_26s_12s_26_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 26,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 26
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] quotient,
   output logic [din1_WIDTH-1:0] remainder,
   output logic                  div_by_zero,
   output logic                  overflow
);

   localparam int NW = din0_WIDTH;
   localparam int DW = din1_WIDTH;
   localparam int CW = $clog2(din0_WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t          state_reg, state_next;
   logic [NW:0]     dvd_reg;       // dividend magnitude, becomes quotient magnitude
   logic [DW:0]     dsr_reg;       // divisor magnitude
   logic [DW:0]     rem_reg;       // partial remainder
   logic            neg0_reg, neg1_reg;
   logic [CW-1:0]   cnt_reg;
   logic            done_reg, dbz_reg, ovf_reg;
   logic [NW-1:0]   quot_reg;
   logic [DW-1:0]   rem_out_reg;

   logic            accept;
   logic [NW:0]     din0_ext, din0_mag, dvd_next;
   logic [DW:0]     din1_ext, din1_mag, rem_shift, rem_next;
   logic [DW+1:0]   diff;
   logic            q_bit, q_neg, dbz_fix, ovf_fix;
   logic [NW-1:0]   q_low, q_fix;
   logic [DW-1:0]   r_low, r_fix;
   logic [32:0]     unused_bits;

   assign accept = ce && start && (state_reg == S_IDLE);

   // Widen by one bit before negating so the most negative dividend has a magnitude.
   assign din0_ext = {din0[NW-1], din0};
   assign din0_mag = din0[NW-1] ? (~din0_ext + 1'b1) : din0_ext;
   assign din1_ext = {din1[DW-1], din1};
   assign din1_mag = din1[DW-1] ? (~din1_ext + 1'b1) : din1_ext;

   assign rem_shift = {rem_reg[DW-1:0], dvd_reg[NW-1]};
   assign diff      = {1'b0, rem_shift} - {1'b0, dsr_reg};
   assign q_bit     = ~diff[DW+1];
   assign rem_next  = q_bit ? diff[DW:0] : rem_shift;
   assign dvd_next  = {1'b0, dvd_reg[NW-2:0], q_bit};

   assign q_neg   = neg0_reg ^ neg1_reg;
   assign q_low   = dvd_reg[NW-1:0];
   assign r_low   = rem_reg[DW-1:0];
   assign dbz_fix = (dsr_reg == '0);
   // A positive magnitude reaching 2^(NW-1) only happens for min / -1.
   assign ovf_fix = !dbz_fix && !q_neg && dvd_reg[NW-1];
   assign q_fix   = dbz_fix ? '1 : (q_neg ? (~q_low + 1'b1) : q_low);
   assign r_fix   = dbz_fix ? '0 : (neg0_reg ? (~r_low + 1'b1) : r_low);

   assign unused_bits = {dvd_reg[NW], 32'(ID)};

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_reg <= S_IDLE;
      end else if (ce) begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start) state_next = S_CALC;
         S_CALC:  if (cnt_reg == CW'(1)) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_reg == S_IDLE);
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         dvd_reg     <= '0;
         dsr_reg     <= '0;
         rem_reg     <= '0;
         neg0_reg    <= 1'b0;
         neg1_reg    <= 1'b0;
         cnt_reg     <= '0;
         done_reg    <= 1'b0;
         dbz_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
         quot_reg    <= '0;
         rem_out_reg <= '0;
      end else if (ce) begin
         done_reg <= (state_reg == S_FIX);
         if (accept) begin
            dvd_reg  <= din0_mag;
            dsr_reg  <= din1_mag;
            rem_reg  <= '0;
            neg0_reg <= din0[NW-1];
            neg1_reg <= din1[DW-1];
            cnt_reg  <= CW'(NW);
         end else if (state_reg == S_CALC) begin
            dvd_reg <= dvd_next;
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg - 1'b1;
         end
         if (state_reg == S_FIX) begin
            quot_reg    <= q_fix;
            rem_out_reg <= r_fix;
            dbz_reg     <= dbz_fix;
            ovf_reg     <= ovf_fix;
         end
      end
   end

   assign done        = done_reg;
   assign quotient    = dout_WIDTH'(quot_reg);
   assign remainder   = rem_out_reg;
   assign div_by_zero = dbz_reg;
   assign overflow    = ovf_reg;

endmodule

// File: tb/tb_case_7_sdiv_26s_12s_26_seq.sv
// Directed bench for the sequential signed divider: latency, signs, flags,
// ignored start, ce stall, done hold under ce=0, async reset abort.
module tb_case_7_sdiv_26s_12s_26_seq;

   logic               ap_clk = 1'b0;
   logic               ap_rst, ce, start;
   logic [25:0]        din0;
   logic [11:0]        din1;
   logic               ready, done, div_by_zero, overflow;
   logic signed [25:0] quotient;
   logic signed [11:0] remainder;

   int n_chk  = 0;
   int n_pass = 0;

   case_7_sdiv_26s_12s_26_seq #(
      .ID(1), .din0_WIDTH(26), .din1_WIDTH(12), .dout_WIDTH(26)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
      .din0(din0), .din1(din1), .ready(ready), .done(done),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                    tag, $signed(obs), obs, $signed(exp), exp);
   endtask

   task automatic do_div(input string tag, input int a, input int b, input int eq, input int er,
                         input bit edbz, input bit eovf, input int elat,
                         input bit stall, input bit poke, input bit hold);
      int lat;
      bit got;
      bit rdy_bad;
      @(negedge ap_clk);
      din0  = a[25:0];
      din1  = b[11:0];
      start = 1'b1;
      @(posedge ap_clk); #1;
      start   = 1'b0;
      lat     = 0;
      got     = 1'b0;
      rdy_bad = 1'b0;
      for (int e = 1; e <= 200 && !got; e++) begin
         @(posedge ap_clk); #1;
         lat = e;
         if (done) got = 1'b1;
         else begin
            if (ready) rdy_bad = 1'b1;
            ce = !(stall && e >= 10 && e < 15);
            if (poke && e == 10) begin
               din0  = 26'(-5000);
               din1  = 12'd3;
               start = 1'b1;
            end
            if (poke && e == 11) start = 1'b0;
         end
      end
      ce = 1'b1;
      chk({tag, "_done"}, 32'(got), 32'd1);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
      chk({tag, "_ovf"}, 32'(overflow), 32'(eovf));
      chk({tag, "_busy_ready"}, 32'(rdy_bad), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b lat=%0d",
               tag, a, b, quotient, remainder, div_by_zero, overflow, lat);
      if (hold) begin
         ce = 1'b0;
         repeat (3) @(posedge ap_clk);
         #1;
         chk({tag, "_done_hold"}, 32'(done), 32'd1);
         ce = 1'b1;
      end
      @(posedge ap_clk); #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_q_held"}, quotient, eq);
   endtask

   task automatic count_dones(input string tag, input int cycles);
      int nd = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge ap_clk); #1;
         if (done) nd++;
      end
      chk(tag, nd, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int a, b;
      ap_rst = 1'b1;
      ce     = 1'b1;
      start  = 1'b0;
      din0   = '0;
      din1   = '0;
      repeat (2) @(posedge ap_clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", quotient, 32'd0);
      chk("rst_r", remainder, 32'd0);
      chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
      @(negedge ap_clk);
      ap_rst = 1'b0;

      do_div("basic",   100,  7,  14,  2, 0, 0, 27, 0, 0, 0);
      do_div("neg_dvd", -100, 7, -14, -2, 0, 0, 27, 0, 0, 0);
      do_div("neg_dsr", 100, -7, -14,  2, 0, 0, 27, 0, 0, 0);
      do_div("neg_both", -100, -7, 14, -2, 0, 0, 27, 0, 0, 0);
      do_div("ovf", -33554432, -1, -33554432, 0, 0, 1, 27, 0, 0, 0);
      do_div("min_p1", -33554432, 1, -33554432, 0, 0, 0, 27, 0, 0, 0);
      do_div("max_dsr", 33554431, -2048, -16383, 2047, 0, 0, 27, 0, 0, 0);
      do_div("poke", 100, 7, 14, 2, 0, 0, 27, 0, 1, 0);
      count_dones("poke_one_done", 30);
      do_div("stall", 100, 7, 14, 2, 0, 0, 32, 1, 0, 0);
      do_div("hold", -1000, 9, -111, -1, 0, 0, 27, 0, 0, 1);

      for (int i = 0; i < 20; i++) begin
         a = $signed($urandom) >>> 6;
         b = int'($urandom_range(0, 4095)) - 2048;
         if (b == 0) b = 5;
         if (a == -33554432 && b == -1) b = 3;
         do_div($sformatf("rand%0d", i), a, b, a / b, a % b, 0, 0, 27, 0, 0, 0);
      end

      do_div("dbz", 12345, 0, -1, 0, 1, 0, 27, 0, 0, 0);

      // Abort a computation mid-flight; outputs must clear without a clock edge.
      @(negedge ap_clk);
      din0  = 26'd100;
      din1  = 12'd7;
      start = 1'b1;
      @(posedge ap_clk); #1;
      start = 1'b0;
      repeat (13) @(posedge ap_clk);
      #2;
      ap_rst = 1'b1;
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_q", quotient, 32'd0);
      chk("abort_r", remainder, 32'd0);
      chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      count_dones("abort_no_done", 30);
      do_div("post_rst", 100, 7, 14, 2, 0, 0, 27, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
